// File: rtl/fifoctrl_lvl_if.sv
// Request, status and RAM-port signals of the fifoctrl_lvl FIFO controller.
// The master side drives requests; the slave side is the controller.
interface fifoctrl_lvl_if #(
  parameter int ADDR = 4
);
  logic            flush;
  logic            fifowr;
  logic            fiford;
  logic            statclr;
  logic            fifofull;
  logic            notempty;
  logic            almostfull;
  logic            almostempty;
  logic [ADDR:0]   fifolen;
  logic [ADDR:0]   maxlen;
  logic            ovf;
  logic            udf;
  logic            mem_wr;
  logic [ADDR-1:0] mem_wa;
  logic            mem_rd;
  logic [ADDR-1:0] mem_ra;

  modport master (
    output flush, fifowr, fiford, statclr,
    input  fifofull, notempty, almostfull, almostempty, fifolen, maxlen,
           ovf, udf, mem_wr, mem_wa, mem_rd, mem_ra
  );

  modport slave (
    input  flush, fifowr, fiford, statclr,
    output fifofull, notempty, almostfull, almostempty, fifolen, maxlen,
           ovf, udf, mem_wr, mem_wa, mem_rd, mem_ra
  );
endinterface

// File: rtl/fifoctrl_lvl.sv
// Synchronous FIFO controller for an external dual-port RAM: pointers, level,
// programmable almost-full/empty, flush, sticky ovf/udf and peak-level watermark.
module fifoctrl_lvl #(
  parameter int ADDR      = 4,
  parameter int AF_LVL    = 12,
  parameter int AE_LVL    = 3,
  parameter bit RDWR_FULL = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  fifoctrl_lvl_if.slave   bus
);

  localparam int            LW    = ADDR + 1;
  localparam logic [ADDR:0] DEPTH = LW'(2 ** ADDR);
  localparam logic [ADDR:0] AF_TH = LW'(AF_LVL);
  localparam logic [ADDR:0] AE_TH = LW'(AE_LVL);

  logic [ADDR-1:0] wr_ptr, rd_ptr;
  logic [ADDR:0]   len, maxlen_q;
  logic            ovf_q, udf_q;
  logic            full, wr_acc, rd_acc, ovf_set, udf_set;

  // NOTE: every signal written in always_comb gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    full    = (len == DEPTH);
    // Strobes are held low while reset is asserted so the RAM is never written
    // from stale pointer state.
    rd_acc  = rst_n & bus.fiford & (len != '0) & ~bus.flush;
    wr_acc  = rst_n & bus.fifowr & ~bus.flush & (~full | (RDWR_FULL & rd_acc));
    ovf_set = bus.fifowr & ~wr_acc & ~bus.flush;
    udf_set = bus.fiford & ~rd_acc & ~bus.flush;
  end

  always_comb begin
    bus.fifofull    = full;
    bus.notempty    = (len != '0);
    bus.almostfull  = (len >= AF_TH);
    bus.almostempty = (len <= AE_TH);
    bus.fifolen     = len;
    bus.maxlen      = maxlen_q;
    bus.ovf         = ovf_q;
    bus.udf         = udf_q;
    bus.mem_wr      = wr_acc;
    bus.mem_wa      = wr_ptr;
    bus.mem_rd      = rd_acc;
    bus.mem_ra      = rd_ptr;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      len    <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      len    <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   len <= len + 1'b1;
        2'b01:   len <= len - 1'b1;
        default: len <= len;
      endcase
    end
  end

  // Statistics survive a flush; a set event in the same cycle as statclr wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      maxlen_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else if (!bus.flush) begin
      ovf_q <= ovf_set | (ovf_q & ~bus.statclr);
      udf_q <= udf_set | (udf_q & ~bus.statclr);
      if (len > maxlen_q)
        maxlen_q <= len;
      else if (bus.statclr)
        maxlen_q <= '0;
    end
  end

endmodule

// File: tb/tb_fifoctrl_lvl.sv
// Self-checking bench for fifoctrl_lvl: RDWR_FULL=0 and =1 instances share
// stimulus and are each compared against a queue-based reference model.
module tb_fifoctrl_lvl;
  localparam int ADDR  = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifoctrl_lvl_if #(.ADDR(ADDR)) if0 ();
  fifoctrl_lvl_if #(.ADDR(ADDR)) if1 ();

  fifoctrl_lvl #(.ADDR(ADDR), .AF_LVL(AF), .AE_LVL(AE), .RDWR_FULL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave)
  );
  fifoctrl_lvl #(.ADDR(ADDR), .AF_LVL(AF), .AE_LVL(AE), .RDWR_FULL(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the FIFO content is a queue of RAM addresses in write order.
  int q0[$];
  int q1[$];
  int m_max[2];
  int m_wcnt[2];
  bit m_ovf[2];
  bit m_udf[2];

  // Inputs of the current cycle, kept for the model update at the clock edge.
  bit s_r, s_wr, s_rd, s_fl, s_sc;
  bit e_wr[2];
  bit e_rd[2];

  function automatic int lvl(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int exp_ra(input int d);
    if (lvl(d) == 0) return m_wcnt[d] % DEPTH;
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  task automatic compare(input int d, input logic wr_s, input logic rd_s,
                         input logic [3:0] wa, input logic [3:0] ra,
                         input logic [4:0] flen, input logic [4:0] mx,
                         input logic full, input logic ne, input logic af,
                         input logic ae, input logic ovf, input logic udf);
    int l;
    l = lvl(d);
    check($sformatf("d%0d mem_wr", d), wr_s, e_wr[d]);
    check($sformatf("d%0d mem_rd", d), rd_s, e_rd[d]);
    check($sformatf("d%0d mem_wa", d), wa, m_wcnt[d] % DEPTH);
    check($sformatf("d%0d mem_ra", d), ra, exp_ra(d));
    check($sformatf("d%0d fifolen", d), flen, l);
    check($sformatf("d%0d maxlen", d), mx, m_max[d]);
    check($sformatf("d%0d fifofull", d), full, l == DEPTH);
    check($sformatf("d%0d notempty", d), ne, l != 0);
    check($sformatf("d%0d almostfull", d), af, l >= AF);
    check($sformatf("d%0d almostempty", d), ae, l <= AE);
    check($sformatf("d%0d ovf", d), ovf, m_ovf[d]);
    check($sformatf("d%0d udf", d), udf, m_udf[d]);
  endtask

  // Drive one cycle of requests away from the edge and compare both instances.
  task automatic drive(input bit r, input bit wr, input bit rd, input bit fl, input bit sc);
    @(negedge clk);
    rst_n = r;
    if0.fifowr = wr; if0.fiford = rd; if0.flush = fl; if0.statclr = sc;
    if1.fifowr = wr; if1.fiford = rd; if1.flush = fl; if1.statclr = sc;
    s_r = r; s_wr = wr; s_rd = rd; s_fl = fl; s_sc = sc;
    for (int d = 0; d < 2; d++) begin
      e_rd[d] = r && rd && !fl && lvl(d) > 0;
      e_wr[d] = r && wr && !fl && (lvl(d) < DEPTH || (d == 1 && e_rd[d]));
    end
    #1;
    compare(0, if0.mem_wr, if0.mem_rd, if0.mem_wa, if0.mem_ra, if0.fifolen, if0.maxlen,
            if0.fifofull, if0.notempty, if0.almostfull, if0.almostempty, if0.ovf, if0.udf);
    compare(1, if1.mem_wr, if1.mem_rd, if1.mem_wa, if1.mem_ra, if1.fifolen, if1.maxlen,
            if1.fifofull, if1.notempty, if1.almostfull, if1.almostempty, if1.ovf, if1.udf);
  endtask

  task automatic tick();
    int old_len;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      old_len = lvl(d);
      if (!s_r) begin
        m_max[d] = 0; m_wcnt[d] = 0; m_ovf[d] = 0; m_udf[d] = 0;
        if (d == 0) q0.delete(); else q1.delete();
      end else if (s_fl) begin
        m_wcnt[d] = 0;
        if (d == 0) q0.delete(); else q1.delete();
      end else begin
        if (old_len > m_max[d]) m_max[d] = old_len;
        else if (s_sc) m_max[d] = 0;
        m_ovf[d] = (s_wr && !e_wr[d]) || (m_ovf[d] && !s_sc);
        m_udf[d] = (s_rd && !e_rd[d]) || (m_udf[d] && !s_sc);
        if (e_rd[d]) begin
          if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        if (e_wr[d]) begin
          if (d == 0) q0.push_back(m_wcnt[d] % DEPTH); else q1.push_back(m_wcnt[d] % DEPTH);
          m_wcnt[d]++;
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit wr, input bit rd, input bit fl, input bit sc);
    drive(r, wr, rd, fl, sc);
    tick();
  endtask

  initial begin
    int wr_total;
    int wr_pct, rd_pct;
    bit w, r;
    if0.fifowr = 0; if0.fiford = 0; if0.flush = 0; if0.statclr = 0;
    if1.fifowr = 0; if1.fiford = 0; if1.flush = 0; if1.statclr = 0;
    for (int d = 0; d < 2; d++) begin
      m_max[d] = 0; m_wcnt[d] = 0; m_ovf[d] = 0; m_udf[d] = 0;
    end
    repeat (2) @(posedge clk);

    // Reset held with requests active: strobes stay low.
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);

    // 16 writes, addresses 0..15.
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 0, 0, 0);
      check("fill mem_wa", if0.mem_wa, i);
      tick();
    end
    drive(1, 0, 0, 0, 0);
    check("fill len", if0.fifolen, 16);
    check("fill full", if0.fifofull, 1);
    tick();

    // 17th write is rejected.
    drive(1, 1, 0, 0, 0);
    check("full maxlen", if0.maxlen, 16);
    check("full17 mem_wr", if0.mem_wr, 0);
    tick();
    drive(1, 0, 0, 0, 0);
    check("full17 ovf", if0.ovf, 1);
    check("full17 len", if0.fifolen, 16);
    tick();
    cyc(1, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0);
    check("statclr ovf", if0.ovf, 0);
    tick();
    drive(1, 0, 0, 0, 0);
    check("statclr maxlen", if0.maxlen, 16);
    tick();

    // Read and write together while full.
    drive(1, 1, 1, 0, 0);
    check("rdwr1 mem_wr", if1.mem_wr, 1);
    check("rdwr1 mem_rd", if1.mem_rd, 1);
    check("rdwr1 mem_wa", if1.mem_wa, 0);
    check("rdwr1 mem_ra", if1.mem_ra, 0);
    check("rdwr0 mem_wr", if0.mem_wr, 0);
    tick();
    drive(1, 0, 0, 0, 0);
    check("rdwr1 len", if1.fifolen, 16);
    check("rdwr0 len", if0.fifolen, 15);
    check("rdwr0 ovf", if0.ovf, 1);
    tick();

    // Drain, then underflow cases.
    repeat (18) cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 1);
    drive(1, 0, 1, 0, 0);
    check("empty mem_rd", if0.mem_rd, 0);
    tick();
    drive(1, 0, 0, 0, 0);
    check("empty udf", if0.udf, 1);
    tick();
    cyc(1, 0, 0, 0, 1);
    drive(1, 1, 1, 0, 0);
    check("empty rdwr mem_wr", if0.mem_wr, 1);
    check("empty rdwr mem_rd", if0.mem_rd, 0);
    tick();
    drive(1, 0, 0, 0, 0);
    check("empty rdwr len", if0.fifolen, 1);
    check("empty rdwr udf", if0.udf, 1);
    tick();

    // Interleaved traffic at level 2..5, pointers wrap.
    wr_total = 0;
    while (wr_total < 40) begin
      if (lvl(0) <= 2) begin w = 1; r = 0; end
      else if (lvl(0) >= 5) begin w = 0; r = 1; end
      else begin w = $urandom_range(0, 1); r = $urandom_range(0, 1); end
      if (w) wr_total++;
      cyc(1, w, r, 0, 0);
    end

    // Flush at level 6 with a write pending.
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1);
    repeat (6) cyc(1, 1, 0, 0, 0);
    repeat (2) cyc(1, 0, 0, 0, 0);
    drive(1, 1, 0, 1, 0);
    check("flush mem_wr", if0.mem_wr, 0);
    tick();
    drive(1, 0, 0, 0, 0);
    check("flush len", if0.fifolen, 0);
    check("flush wa", if0.mem_wa, 0);
    check("flush ra", if0.mem_ra, 0);
    check("flush ovf", if0.ovf, 0);
    check("flush maxlen", if0.maxlen, 6);
    tick();

    // Randomized traffic in biased blocks to reach both full and empty.
    for (int b = 0; b < 30; b++) begin
      wr_pct = $urandom_range(20, 90);
      rd_pct = $urandom_range(20, 90);
      for (int i = 0; i < 100; i++) begin
        cyc(($urandom_range(0, 199) != 0),
            ($urandom_range(0, 99) < wr_pct),
            ($urandom_range(0, 99) < rd_pct),
            ($urandom_range(0, 99) < 2),
            ($urandom_range(0, 99) < 3));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifoctrl_lvl.md
# fifoctrl_lvl

Parametrised synchronous FIFO controller: write/read pointers, fill level and status for an externally instantiated dual-port memory (one write port, one read port, same clock). Next generation of the basic FIFO controller: it adds programmable almost-full/almost-empty levels, flush, optional write-on-full-with-read, sticky overflow/underflow flags and a peak-level watermark. It sits between a producer/consumer pair and a generic RAM macro in datapath buffering.

## Interface
- ADDR, 4: address width; depth = 2^ADDR entries.
- AF_LVL, 12: almostfull asserts when level >= AF_LVL. Legal range AE_LVL < AF_LVL <= 2^ADDR.
- AE_LVL, 3: almostempty asserts when level <= AE_LVL.
- RDWR_FULL, 0: 1 = a write is accepted when full if a read is accepted in the same cycle (requires read-before-write RAM).

- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- flush  in  1  synchronous empty; discards contents.
- fifowr  in  1  write request.
- fiford  in  1  read request.
- statclr  in  1  clears ovf, udf, maxlen.
- fifofull  out  1  level == 2^ADDR.
- notempty  out  1  level != 0.
- almostfull  out  1  level >= AF_LVL.
- almostempty  out  1  level <= AE_LVL.
- fifolen  out  ADDR+1  current level, 0..2^ADDR.
- maxlen  out  ADDR+1  peak level since reset/statclr.
- ovf  out  1  sticky: write request rejected.
- udf  out  1  sticky: read request rejected.
- mem_wr  out  1  memory write strobe.
- mem_wa  out  ADDR  memory write address.
- mem_rd  out  1  memory read strobe.
- mem_ra  out  ADDR  memory read address.

## Operation
- State: wr_ptr, rd_ptr (ADDR bits, wrap modulo 2^ADDR), len (ADDR+1 bits), maxlen, ovf, udf. mem_wa = wr_ptr, mem_ra = rd_ptr.
- mem_rd = fiford & notempty & !flush.
- mem_wr = fifowr & !flush & (!fifofull | (RDWR_FULL & mem_rd)).
- Accepted write: wr_ptr += 1. Accepted read: rd_ptr += 1. len: +1 on write only, -1 on read only, unchanged on both or neither.
- flush: wr_ptr, rd_ptr, len -> 0 next cycle; mem_wr/mem_rd forced 0 that cycle; ovf, udf, maxlen untouched; fifowr/fiford in a flush cycle set no error flags.
- ovf set when fifowr & !mem_wr & !flush. udf set when fiford & !mem_rd & !flush.
- maxlen loads len when len > maxlen (compare on registered len).
- statclr: ovf, udf, maxlen -> 0; a set event in the same cycle wins (flag -> 1, maxlen -> len).
- Priority per register: rst_n > flush > normal update.
- Status flags decoded from registered len only; no combinational path from fifowr/fiford to any status output.

## Timing
- Reset (rst_n low at clk edge): all pointers, len, maxlen, ovf, udf = 0; hence fifofull=0, notempty=0, almostfull=0 (AF_LVL>0), almostempty=1, mem_wr=mem_rd=0 while rst_n low.
- mem_wr/mem_rd combinational from same-cycle requests; mem_wa/mem_ra valid the cycle the strobe is high.
- fifolen and all status outputs update the cycle after the accepted transfer (latency 1).
- maxlen lags len by one cycle; ovf/udf set the cycle after the rejected request.
- Read data latency is the RAM's; the controller provides address only.
- Full with RDWR_FULL=0: simultaneous rd+wr -> read accepted, write rejected, ovf=1, len = 2^ADDR-1.
- Empty: simultaneous rd+wr -> write accepted, read rejected, udf=1, len = 1.
- Wrap: pointers roll 2^ADDR-1 -> 0 without affecting len.
- Reset or flush mid-stream: takes effect at that edge; no partial transfer.

## Test plan
- Reset, then 16 writes, no reads (ADDR=4) -> len 1..16; almostfull from 12th write's next cycle; fifofull after 16th; mem_wa 0..15; maxlen=16.
- Full, 17th write -> mem_wr=0, ovf=1 next cycle, len stays 16; statclr -> ovf=0, maxlen=16 (reloaded from len).
- Full, RDWR_FULL=1, rd+wr same cycle -> mem_wr=mem_rd=1, mem_wa=mem_ra=0, len stays 16; RDWR_FULL=0 same stimulus -> len=15, ovf=1.
- Empty, read request -> mem_rd=0, udf=1; simultaneous rd+wr on empty -> len=1, udf=1.
- 40 writes interleaved with 40 reads, level held 2..5 -> pointers wrap twice, mem_ra follows write order, almostempty toggles at level 3/4.
- 6 entries, flush with fifowr=1 -> mem_wr=0, len=0, pointers=0 next cycle, ovf=0, maxlen=6 unchanged.
